dcache_assoc_sram: RTL and testbench
====================================

DCACHE_ASSOC_SRAM -- requirements
Module: dcache_assoc_sram

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 2, associativity; power of two, 1..8.
REQ-002 SHALL have parameter NUM_SETS, default 64, sets per way; power of two.
REQ-003 SHALL have parameter BLOCK_BYTES, default 32, bytes per block; power of two.
REQ-004 SHALL have parameter ADDR_W, default 32, byte-address width; BA_W = ADDR_W - log2(BLOCK_BYTES), TAG_W = BA_W - log2(NUM_SETS).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 ren  in  1  CPU read lookup.
REQ-008 wen  in  1  CPU byte-masked write lookup.
REQ-009 memWen  in  1  block fill from memory.
REQ-010 bytesAccess  in  BLOCK_BYTES  byte enables for wen.
REQ-011 blockAddr  in  BA_W  block address; low log2(NUM_SETS) bits = set index, rest = tag.
REQ-012 dataIn  in  BLOCK_BYTES*8  write/fill data, byte i at bits [8i+7:8i].
REQ-013 respValid  out  1  response strobe for previous-cycle request.
REQ-014 hit  out  1  lookup hit.
REQ-015 dirtyBit  out  1  selected victim valid and dirty (miss only).
REQ-016 victimAddr  out  BA_W  block address of selected victim (miss only).
REQ-017 dataOut  out  BLOCK_BYTES*8  hit: block data after any write; miss with dirtyBit: victim data.

Function
REQ-018 Request accepted every cycle any of ren/wen/memWen is 1; priority memWen > wen > ren; lower-priority strobes that cycle SHALL be ignored.
REQ-019 Response SHALL appear exactly one cycle after acceptance with respValid=1 for one cycle; respValid=0 otherwise; fully pipelined, back-to-back requests allowed.
REQ-020 Hit = some way in the set has valid=1 and matching tag; at most one way may match.
REQ-021 Read hit: hit=1, dataOut=block, PLRU updated to mark way most-recent.
REQ-022 Write hit: bytes with bytesAccess[i]=1 replaced, others kept, dirty set, PLRU updated; dataOut SHALL show merged block; bytesAccess=0 SHALL change only PLRU.
REQ-023 Read/write miss: no array or PLRU change; hit=0; victim = lowest-index invalid way, else PLRU way; dirtyBit, victimAddr, dataOut describe victim.
REQ-024 Fill (memWen): if tag present, overwrite that way; else overwrite victim per REQ-023; valid=1, dirty=0, tag written, PLRU updated; response hit=0, dirtyBit=0.
REQ-025 Request to same set/block in the next cycle SHALL observe the previous write/fill (no stale read).
REQ-026 PLRU: tree pseudo-LRU per set, NUM_WAYS-1 bits; NUM_WAYS=1 SHALL behave direct-mapped with no PLRU state.
REQ-027 Outputs other than respValid SHALL hold last value when respValid=0.

Reset
REQ-028 rst=0 SHALL immediately clear all valid, dirty and PLRU bits and force respValid, hit, dirtyBit=0, victimAddr=0, dataOut=0.
REQ-029 A request in flight at reset assertion SHALL be dropped with no response; data and tag arrays need no reset.
REQ-030 First request SHALL be accepted on the first rising edge with rst=1.

Structure
REQ-031 Shared package dcache_pkg SHALL hold the default parameters and derived widths BA_W, TAG_W, SET_W.
REQ-032 Sub-module plru_tree (victim select and update for one set) SHALL be used.

Verification
REQ-033 Reset, then ren to 0x0040 -> next cycle respValid=1, hit=0, dirtyBit=0.
REQ-034 Fill 0x0040 with 0xA5 pattern, ren 0x0040 -> hit=1, dataOut all 0xA5.
REQ-035 wen 0x0040 bytesAccess=0x1, dataIn byte0=0x3C -> hit=1, byte0=0x3C, rest 0xA5; then miss in same set with both ways valid -> dirtyBit=1, victimAddr=0x0040 if it is PLRU victim.
REQ-036 2-way: fill A, B in set 0, read A, miss C -> victimAddr=B.
REQ-037 memWen, wen, ren same cycle -> only fill performed, hit=0.
REQ-038 rst=0 mid-request -> no respValid; following read of previously filled block -> hit=0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache.
// Holds the default geometry, the address widths derived from it, the request
// opcode type and small helpers for sizing way indices and PLRU vectors.
package dcache_pkg;

  localparam int unsigned NUM_WAYS_DEF    = 2;
  localparam int unsigned NUM_SETS_DEF    = 64;
  localparam int unsigned BLOCK_BYTES_DEF = 32;
  localparam int unsigned ADDR_W_DEF      = 32;

  // Widths for the default geometry.
  localparam int unsigned SET_W = $clog2(NUM_SETS_DEF);
  localparam int unsigned BA_W  = ADDR_W_DEF - $clog2(BLOCK_BYTES_DEF);
  localparam int unsigned TAG_W = BA_W - SET_W;

  typedef enum logic [1:0] {
    OpNone,
    OpRead,
    OpWrite,
    OpFill
  } op_e;

  // Width of a way index; at least one bit so the direct-mapped case still has a port.
  function automatic int unsigned way_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tree PLRU needs one bit per internal node.
  function automatic int unsigned plru_bits(input int unsigned n);
    return (n > 1) ? n - 1 : 1;
  endfunction

  // Fill beats write, write beats read; losers in the same cycle are dropped.
  function automatic op_e decode_op(input logic rd, input logic wr, input logic fill);
    if (fill) begin
      return OpFill;
    end else if (wr) begin
      return OpWrite;
    end else if (rd) begin
      return OpRead;
    end
    return OpNone;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU helper for one cache set.
// Ports:
//   state      - current PLRU node bits of the set (heap order, node 0 = root)
//   valid      - per-way valid bits of the set
//   access_way - way being touched this cycle
//   victim_way - lowest-index invalid way, otherwise the way the tree points at
//   next_state - node bits after marking access_way most recently used
// A node bit of 1 means the older half is the right subtree.
module plru_tree
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_DEF,
  localparam int unsigned WAY_W   = way_bits(NUM_WAYS),
  localparam int unsigned PLRU_W  = plru_bits(NUM_WAYS)
) (
  input  logic [PLRU_W-1:0]   state,
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    access_way,
  output logic [WAY_W-1:0]    victim_way,
  output logic [PLRU_W-1:0]   next_state
);

  localparam int unsigned LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;

  logic [WAY_W-1:0] tree_way;

  // Walk root to leaf; the accumulated path bits are the leaf (way) number.
  always_comb begin
    int unsigned acc;
    int unsigned node;
    logic        bit_v;
    acc   = 0;
    node  = 0;
    bit_v = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      node  = (32'd1 << l) - 32'd1 + acc;
      bit_v = 1'b0;
      for (int unsigned n = 0; n < PLRU_W; n++) begin
        if (n == node) bit_v = state[n];
      end
      acc = (acc << 1) + (bit_v ? 32'd1 : 32'd0);
    end
    tree_way = WAY_W'(acc);
  end

  // Invalid ways are always preferred so a set fills up before anything is evicted.
  always_comb begin
    victim_way = tree_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim_way = WAY_W'(w);
    end
  end

  // Kept separate from the victim walk: access_way depends on victim_way upstream.
  always_comb begin
    int unsigned aw;
    int unsigned node;
    int unsigned prefix;
    logic        dir;
    aw         = 32'(access_way);
    node       = 0;
    prefix     = 0;
    dir        = 1'b0;
    next_state = state;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      prefix = aw >> (LEVELS - l);
      node   = (32'd1 << l) - 32'd1 + prefix;
      dir    = ((aw >> (LEVELS - 1 - l)) & 32'd1) != 32'd0;
      for (int unsigned n = 0; n < PLRU_W; n++) begin
        if (n == node) next_state[n] = ~dir;
      end
    end
  end

endmodule

// File: rtl/dcache_assoc_sram.sv
// Set-associative data cache array with tree-PLRU replacement.
// One request per cycle (memWen > wen > ren); the response is registered and
// appears on the following cycle with respValid high.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   ren/wen/memWen  - read lookup, byte-masked write lookup, block fill
//   bytesAccess     - byte enables for wen
//   blockAddr       - {tag, set index}
//   dataIn          - write/fill data, byte i at [8i+7:8i]
//   respValid       - response strobe
//   hit             - lookup hit
//   dirtyBit        - on a miss, chosen victim is valid and dirty
//   victimAddr      - on a miss, block address of the chosen victim
//   dataOut         - on a hit the (merged) block, on a miss the victim block
module dcache_assoc_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS    = NUM_WAYS_DEF,
  parameter int unsigned NUM_SETS    = NUM_SETS_DEF,
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  localparam int unsigned SET_BITS   = $clog2(NUM_SETS),
  localparam int unsigned BLK_AW     = ADDR_W - $clog2(BLOCK_BYTES),
  localparam int unsigned TAG_BITS   = BLK_AW - SET_BITS,
  localparam int unsigned DATA_W     = BLOCK_BYTES * 8,
  localparam int unsigned WAY_W      = way_bits(NUM_WAYS),
  localparam int unsigned PLRU_W     = plru_bits(NUM_WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren,
  input  logic                   wen,
  input  logic                   memWen,
  input  logic [BLOCK_BYTES-1:0] bytesAccess,
  input  logic [BLK_AW-1:0]      blockAddr,
  input  logic [DATA_W-1:0]      dataIn,
  output logic                   respValid,
  output logic                   hit,
  output logic                   dirtyBit,
  output logic [BLK_AW-1:0]      victimAddr,
  output logic [DATA_W-1:0]      dataOut
);

  op_e                 op;
  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] req_tag;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_dirty;
  logic [NUM_WAYS-1:0] tag_match;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic [WAY_W-1:0]    access_way;

  logic [PLRU_W-1:0]   plru_rd;
  logic [PLRU_W-1:0]   plru_nxt;

  logic [DATA_W-1:0]   hit_data;
  logic [DATA_W-1:0]   merged_data;
  logic [DATA_W-1:0]   victim_data;
  logic [TAG_BITS-1:0] victim_tag;

  logic                plru_we;
  logic                fill_we;
  logic                wr_we;

  logic                resp_hit_d;
  logic                resp_dirty_d;
  logic [BLK_AW-1:0]   resp_va_d;
  logic [DATA_W-1:0]   resp_data_d;

  // Storage: valid/dirty are reset, tag/data are not.
  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [NUM_SETS-1:0] dirty_q [NUM_WAYS];
  logic [TAG_BITS-1:0] tag_q   [NUM_WAYS][NUM_SETS];
  logic [DATA_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];

  assign set_idx = blockAddr[SET_BITS-1:0];
  assign req_tag = blockAddr[BLK_AW-1:SET_BITS];

  // Tag lookup across all ways of the addressed set.
  always_comb begin
    op      = decode_op(ren, wen, memWen);
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_valid[w] = valid_q[w][set_idx];
      way_dirty[w] = dirty_q[w][set_idx];
      tag_match[w] = way_valid[w] && (tag_q[w][set_idx] == req_tag);
      if (tag_match[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  plru_tree #(
    .NUM_WAYS(NUM_WAYS)
  ) u_plru_tree (
    .state     (plru_rd),
    .valid     (way_valid),
    .access_way(access_way),
    .victim_way(victim_way),
    .next_state(plru_nxt)
  );

  // Way selection, byte merge and write enables.
  always_comb begin
    access_way  = hit_any ? hit_way : victim_way;
    hit_data    = data_q[hit_way][set_idx];
    victim_data = data_q[victim_way][set_idx];
    victim_tag  = tag_q[victim_way][set_idx];
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      merged_data[8*i +: 8] = bytesAccess[i] ? dataIn[8*i +: 8] : hit_data[8*i +: 8];
    end
    plru_we = 1'b0;
    fill_we = 1'b0;
    wr_we   = 1'b0;
    unique case (op)
      OpFill: begin
        plru_we = 1'b1;
        fill_we = 1'b1;
      end
      OpWrite: begin
        plru_we = hit_any;
        // An all-zero byte mask is a pure touch: no data change, block stays clean.
        wr_we   = hit_any && (|bytesAccess);
      end
      OpRead:  plru_we = hit_any;
      default: ;
    endcase
  end

  // Response contents for the request presented this cycle.
  always_comb begin
    resp_hit_d   = (op != OpFill) && hit_any;
    resp_dirty_d = (op != OpFill) && !hit_any &&
                   way_valid[victim_way] && way_dirty[victim_way];
    resp_va_d    = blockAddr;
    resp_data_d  = dataIn;
    if (op != OpFill) begin
      if (hit_any) begin
        resp_data_d = (op == OpWrite) ? merged_data : hit_data;
      end else begin
        resp_va_d   = {victim_tag, set_idx};
        resp_data_d = victim_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else if (fill_we) begin
      valid_q[access_way][set_idx] <= 1'b1;
      dirty_q[access_way][set_idx] <= 1'b0;
    end else if (wr_we) begin
      dirty_q[hit_way][set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[access_way][set_idx]  <= req_tag;
      data_q[access_way][set_idx] <= dataIn;
    end else if (wr_we) begin
      data_q[hit_way][set_idx] <= merged_data;
    end
  end

  if (NUM_WAYS > 1) begin : g_plru
    logic [PLRU_W-1:0] plru_q [NUM_SETS];

    assign plru_rd = plru_q[set_idx];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          plru_q[s] <= '0;
        end
      end else if (plru_we) begin
        plru_q[set_idx] <= plru_nxt;
      end
    end
  end else begin : g_no_plru
    // Direct-mapped: the only way is always the victim.
    assign plru_rd = '0;
  end

  // Outputs hold their last response while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      respValid  <= 1'b0;
      hit        <= 1'b0;
      dirtyBit   <= 1'b0;
      victimAddr <= '0;
      dataOut    <= '0;
    end else begin
      respValid <= (op != OpNone);
      if (op != OpNone) begin
        hit        <= resp_hit_d;
        dirtyBit   <= resp_dirty_d;
        victimAddr <= resp_va_d;
        dataOut    <= resp_data_d;
      end
    end
  end

endmodule

// File: tb/tb_dcache_assoc_sram.sv
// Self-checking bench for dcache_assoc_sram (default 2-way, 64 sets, 32-byte blocks).
// A behavioural cache model (true LRU, which equals tree PLRU for two ways)
// predicts every response; directed steps add hand-computed literal checks.
module tb_dcache_assoc_sram;

  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 64;
  localparam int unsigned BB   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned SW   = 6;
  localparam int unsigned BAW  = 27;
  localparam int unsigned TW   = BAW - SW;
  localparam int unsigned DW   = BB * 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ren = 1'b0;
  logic           wen = 1'b0;
  logic           memWen = 1'b0;
  logic [BB-1:0]  bytesAccess = '0;
  logic [BAW-1:0] blockAddr = '0;
  logic [DW-1:0]  dataIn = '0;
  logic           respValid;
  logic           hit;
  logic           dirtyBit;
  logic [BAW-1:0] victimAddr;
  logic [DW-1:0]  dataOut;

  dcache_assoc_sram #(
    .NUM_WAYS   (WAYS),
    .NUM_SETS   (SETS),
    .BLOCK_BYTES(BB),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ren        (ren),
    .wen        (wen),
    .memWen     (memWen),
    .bytesAccess(bytesAccess),
    .blockAddr  (blockAddr),
    .dataIn     (dataIn),
    .respValid  (respValid),
    .hit        (hit),
    .dirtyBit   (dirtyBit),
    .victimAddr (victimAddr),
    .dataOut    (dataOut)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [DW-1:0] got,
                              input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit             mv    [WAYS][SETS];
  bit             md    [WAYS][SETS];
  logic [TW-1:0]  mt    [WAYS][SETS];
  logic [DW-1:0]  mdat  [WAYS][SETS];
  int unsigned    stamp [WAYS][SETS];
  int unsigned    tick = 0;

  bit             e_rv, e_hit, e_dirty, e_chk_va, e_chk_do;
  logic [BAW-1:0] e_va;
  logic [DW-1:0]  e_do;
  bit             last_hit = 1'b0;
  bit             last_dirty = 1'b0;

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++) begin
      for (int s = 0; s < SETS; s++) begin
        mv[w][s]    = 1'b0;
        md[w][s]    = 1'b0;
        stamp[w][s] = 0;
      end
    end
    last_hit   = 1'b0;
    last_dirty = 1'b0;
  endtask

  // Evaluate the request on the inputs at this clock edge.
  task automatic model_step();
    int            s, hw, v;
    logic [TW-1:0] tg;
    e_rv     = rst && (ren || wen || memWen);
    e_chk_va = 1'b0;
    e_chk_do = 1'b0;
    e_hit    = 1'b0;
    e_dirty  = 1'b0;
    if (!e_rv) return;
    s  = int'(blockAddr[SW-1:0]);
    tg = blockAddr[BAW-1:SW];
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (mv[w][s] && mt[w][s] == tg) hw = w;
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!mv[w][s]) v = w;
    if (v < 0) begin
      v = 0;
      for (int w = 1; w < WAYS; w++) if (stamp[w][s] < stamp[v][s]) v = w;
    end
    tick++;
    if (memWen) begin
      if (hw < 0) hw = v;
      mv[hw][s]    = 1'b1;
      md[hw][s]    = 1'b0;
      mt[hw][s]    = tg;
      mdat[hw][s]  = dataIn;
      stamp[hw][s] = tick;
    end else if (hw >= 0) begin
      if (wen) begin
        for (int i = 0; i < BB; i++) begin
          if (bytesAccess[i]) mdat[hw][s][8*i +: 8] = dataIn[8*i +: 8];
        end
        if (bytesAccess != '0) md[hw][s] = 1'b1;
      end
      stamp[hw][s] = tick;
      e_hit    = 1'b1;
      e_do     = mdat[hw][s];
      e_chk_do = 1'b1;
    end else begin
      e_dirty  = mv[v][s] && md[v][s];
      e_chk_va = mv[v][s];
      e_va     = {mt[v][s], blockAddr[SW-1:0]};
      e_chk_do = e_dirty;
      e_do     = mdat[v][s];
    end
  endtask

  // Compare process: model at the rising edge, DUT sampled at the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (!rst) begin
        chk("rst_respValid", respValid, 0);
        chk("rst_hit", hit, 0);
        chk("rst_dirtyBit", dirtyBit, 0);
        chk("rst_victimAddr", victimAddr, 0);
        chk("rst_dataOut", dataOut, 0);
        model_clear();
      end else if (e_rv) begin
        chk("respValid", respValid, 1);
        chk("hit", hit, e_hit);
        chk("dirtyBit", dirtyBit, e_dirty);
        if (e_chk_va) chk("victimAddr", victimAddr, e_va);
        if (e_chk_do) chk("dataOut", dataOut, e_do);
        last_hit   = e_hit;
        last_dirty = e_dirty;
      end else begin
        chk("idle_respValid", respValid, 0);
        chk("hold_hit", hit, last_hit);
        chk("hold_dirtyBit", dirtyBit, last_dirty);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit w, input bit m, input logic [BB-1:0] be,
                       input logic [BAW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    ren = r; wen = w; memWen = m; bytesAccess = be; blockAddr = a; dataIn = d;
  endtask

  // Go idle and wait until the last request's response is visible.
  task automatic settle();
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 1'b0; memWen = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [BAW-1:0] A = 27'h0040;
  localparam logic [BAW-1:0] B = 27'h0080;
  localparam logic [BAW-1:0] C = 27'h00C0;

  logic [DW-1:0] pat_a5, pat_5a, pat_11, wr3c, merged;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    pat_11 = {32{8'h11}};
    wr3c   = {{31{8'h00}}, 8'h3C};
    merged = {{31{8'hA5}}, 8'h3C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_reset_respValid", respValid, 0);
    chk("lit_reset_hit", hit, 0);
    chk("lit_reset_victimAddr", victimAddr, 0);
    chk("lit_reset_dataOut", dataOut, 0);

    // Release reset and present the first read on the same edge.
    @(posedge clk);
    #1;
    rst = 1'b1; ren = 1'b1; blockAddr = A;
    settle();
    chk("lit_first_respValid", respValid, 1);
    chk("lit_first_hit", hit, 0);
    chk("lit_first_dirty", dirtyBit, 0);

    drive(0, 0, 1, '0, A, pat_a5);
    settle();
    chk("lit_fill_hit", hit, 0);

    drive(1, 0, 0, '0, A, '0);
    settle();
    chk("lit_readA_hit", hit, 1);
    chk("lit_readA_data", dataOut, pat_a5);

    drive(0, 1, 0, 32'h1, A, wr3c);
    settle();
    chk("lit_writeA_hit", hit, 1);
    chk("lit_writeA_data", dataOut, merged);

    drive(0, 0, 1, '0, B, pat_5a);
    drive(1, 0, 0, '0, C, '0);
    settle();
    chk("lit_missC_hit", hit, 0);
    chk("lit_missC_dirty", dirtyBit, 1);
    chk("lit_missC_va", victimAddr, A);
    chk("lit_missC_data", dataOut, merged);

    drive(1, 0, 0, '0, A, '0);
    drive(1, 0, 0, '0, C, '0);
    settle();
    chk("lit_lru_va", victimAddr, B);
    chk("lit_lru_dirty", dirtyBit, 0);

    drive(1, 1, 1, '1, C, pat_11);
    settle();
    chk("lit_prio_hit", hit, 0);
    chk("lit_prio_dirty", dirtyBit, 0);
    drive(1, 0, 0, '0, C, '0);
    settle();
    chk("lit_readC_hit", hit, 1);
    chk("lit_readC_data", dataOut, pat_11);
    drive(1, 0, 0, '0, B, '0);
    settle();
    chk("lit_readB_evicted", hit, 0);

    // Reset lands while a response is pending.
    drive(1, 0, 0, '0, A, '0);
    @(posedge clk);
    #1;
    rst = 1'b0; ren = 1'b0;
    @(negedge clk);
    chk("lit_drop_respValid", respValid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 0, 0, '0, A, '0);
    settle();
    chk("lit_after_rst_valid", respValid, 1);
    chk("lit_after_rst_hit", hit, 0);

    // Randomized traffic on a small address pool to force hits and evictions.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        continue;
      end
      rst         = 1'b1;
      memWen      = ($urandom_range(0, 99) < 18);
      wen         = ($urandom_range(0, 99) < 30);
      ren         = ($urandom_range(0, 99) < 45);
      blockAddr   = (BAW'($urandom_range(0, 3)) << SW) | BAW'($urandom_range(0, 2));
      bytesAccess = ($urandom_range(0, 7) == 0) ? '0 : BB'($urandom);
      for (int k = 0; k < DW / 32; k++) dataIn[32*k +: 32] = $urandom;
    end
    rst = 1'b1;
    settle();
    @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
